// File: rtl/rgb_led_pkg.sv
// Shared constants for the RGB LED fade/PWM stage: default PWM width, full-scale duty
// and channel indices into the 3-bit colour pattern.
package rgb_led_pkg;

    localparam int unsigned PWM_BITS_DEFAULT = 8;
    localparam logic [PWM_BITS_DEFAULT-1:0] MAX_DUTY = '1;

    localparam int unsigned R = 0;
    localparam int unsigned G = 1;
    localparam int unsigned B = 2;

endpackage

// File: rtl/rgb_fade_pwm_if.sv
// Colour-pattern input and LED/status outputs of the RGB fade stage.
// master = upstream driver, slave = rgb_fade_pwm.
interface rgb_fade_pwm_if;

    logic [2:0] rgb_in;
    logic       en;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic       busy;
    logic       period_start;

    modport master (
        output rgb_in,
        output en,
        input  led_r,
        input  led_g,
        input  led_b,
        input  busy,
        input  period_start
    );

    modport slave (
        input  rgb_in,
        input  en,
        output led_r,
        output led_g,
        output led_b,
        output busy,
        output period_start
    );

endinterface

// File: rtl/pwm_channel.sv
// One LED channel: duty register that ramps toward its target on each step strobe,
// plus the registered PWM compare driving the LED pin.
module pwm_channel
    import rgb_led_pkg::*;
#(
    parameter int unsigned PWM_BITS   = PWM_BITS_DEFAULT,
    parameter int unsigned STEP       = 8,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                clk_24M,
    input  logic                rst,
    input  logic                step,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                target_on,
    input  logic                en,
    output logic                led,
    output logic                chan_busy
);

    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS + 1)'(STEP);
    localparam logic [PWM_BITS-1:0] STEP_N = PWM_BITS'(STEP);

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS:0]   dn_floor;
    logic                on;
    logic                led_q, led_d;

    assign target = target_on ? '1 : '0;

    // Extra headroom bit keeps the clamp compares free of wrap-around.
    always_comb begin
        duty_d   = duty_q;
        up_sum   = {1'b0, duty_q} + STEP_W;
        dn_floor = {1'b0, target} + STEP_W;
        if (step) begin
            if (duty_q < target) begin
                duty_d = (up_sum > {1'b0, target}) ? target : up_sum[PWM_BITS-1:0];
            end else if (duty_q > target) begin
                duty_d = ({1'b0, duty_q} >= dn_floor) ? (duty_q - STEP_N) : target;
            end
        end
    end

    always_comb begin
        on    = (duty_q == '1) || (pwm_cnt < duty_q);
        led_d = en ? (on ^ ACTIVE_LOW) : ACTIVE_LOW;
    end

    always_ff @(posedge clk_24M) begin
        if (rst) begin
            duty_q <= '0;
            led_q  <= ACTIVE_LOW;
        end else begin
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led       = led_q;
    assign chan_busy = (duty_q != target);

endmodule

// File: rtl/rgb_fade_pwm.sv
// Crossfading RGB PWM driver: prescaler, PWM counter, step divider and input capture,
// feeding three pwm_channel instances.
module rgb_fade_pwm
    import rgb_led_pkg::*;
#(
    parameter int unsigned PWM_BITS     = PWM_BITS_DEFAULT,
    parameter int unsigned PRESCALE     = 94,
    parameter int unsigned STEP_PERIODS = 4,
    parameter int unsigned STEP         = 8,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic           clk_24M,
    input  logic           rst,
    rgb_fade_pwm_if.slave  bus
);

    localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DIV_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                wrap_q, period_start_q;
    logic [2:0]          rgb_q;
    logic                busy_q;

    logic                tick;
    logic                wrap;
    logic                step;
    logic [2:0]          target_on;
    logic [2:0]          led;
    logic [2:0]          chan_busy;

    always_comb begin
        tick      = (presc_q == PS_W'(PRESCALE - 1));
        wrap      = tick && (pwm_cnt_q == '1);
        step      = period_start_q && (div_q == DIV_W'(STEP_PERIODS - 1));
        presc_d   = tick ? '0 : presc_q + PS_W'(1);
        pwm_cnt_d = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        div_d     = div_q;
        if (period_start_q) begin
            div_d = (div_q == DIV_W'(STEP_PERIODS - 1)) ? '0 : div_q + DIV_W'(1);
        end
    end

    // period_start lands one cycle after pwm_cnt has already wrapped to 0.
    always_ff @(posedge clk_24M) begin
        if (rst) begin
            presc_q        <= '0;
            pwm_cnt_q      <= '0;
            div_q          <= '0;
            wrap_q         <= 1'b0;
            period_start_q <= 1'b0;
            rgb_q          <= {3{ACTIVE_LOW}};
            busy_q         <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            div_q          <= div_d;
            wrap_q         <= wrap;
            period_start_q <= wrap_q;
            rgb_q          <= bus.rgb_in;
            busy_q         <= |chan_busy;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            target_on[i] = (rgb_q[i] != ACTIVE_LOW);
        end
    end

    pwm_channel #(
        .PWM_BITS   (PWM_BITS),
        .STEP       (STEP),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan_r (
        .clk_24M   (clk_24M),
        .rst       (rst),
        .step      (step),
        .pwm_cnt   (pwm_cnt_q),
        .target_on (target_on[R]),
        .en        (bus.en),
        .led       (led[R]),
        .chan_busy (chan_busy[R])
    );

    pwm_channel #(
        .PWM_BITS   (PWM_BITS),
        .STEP       (STEP),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan_g (
        .clk_24M   (clk_24M),
        .rst       (rst),
        .step      (step),
        .pwm_cnt   (pwm_cnt_q),
        .target_on (target_on[G]),
        .en        (bus.en),
        .led       (led[G]),
        .chan_busy (chan_busy[G])
    );

    pwm_channel #(
        .PWM_BITS   (PWM_BITS),
        .STEP       (STEP),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan_b (
        .clk_24M   (clk_24M),
        .rst       (rst),
        .step      (step),
        .pwm_cnt   (pwm_cnt_q),
        .target_on (target_on[B]),
        .en        (bus.en),
        .led       (led[B]),
        .chan_busy (chan_busy[B])
    );

    assign bus.led_r        = led[R];
    assign bus.led_g        = led[G];
    assign bus.led_b        = led[B];
    assign bus.busy         = busy_q;
    assign bus.period_start = period_start_q;

endmodule
